// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: NREGS registers of C_S_AXI_DATA_WIDTH bits, byte-strobe
// writes, per-register read-only masking, DECERR for unmapped indices and one-cycle
// write/read event pulses towards the unit under test.
module axi_lite_regbank #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
    parameter int unsigned NREGS              = 16,
    parameter logic [NREGS-1:0] RO_MASK       = '0,
    parameter logic [NREGS-1:0][C_S_AXI_DATA_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                                  S_AXI_ACLK,
    input  logic                                  S_AXI_ARESETN,
    output logic [NREGS*C_S_AXI_DATA_WIDTH-1:0]   slv_reg,
    input  logic [NREGS*C_S_AXI_DATA_WIDTH-1:0]   slv_read,
    output logic [NREGS-1:0]                      wr_pulse,
    output logic [NREGS-1:0]                      rd_pulse,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]         S_AXI_AWADDR,
    input  logic [2:0]                            S_AXI_AWPROT,
    input  logic                                  S_AXI_AWVALID,
    output logic                                  S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]         S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]       S_AXI_WSTRB,
    input  logic                                  S_AXI_WVALID,
    output logic                                  S_AXI_WREADY,
    output logic [1:0]                            S_AXI_BRESP,
    output logic                                  S_AXI_BVALID,
    input  logic                                  S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]         S_AXI_ARADDR,
    input  logic [2:0]                            S_AXI_ARPROT,
    input  logic                                  S_AXI_ARVALID,
    output logic                                  S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]         S_AXI_RDATA,
    output logic [1:0]                            S_AXI_RRESP,
    output logic                                  S_AXI_RVALID,
    input  logic                                  S_AXI_RREADY
);

    localparam int unsigned DW  = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW  = DW / 8;
    localparam int unsigned LSB = $clog2(SW);
    localparam int unsigned IW  = C_S_AXI_ADDR_WIDTH - LSB;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespDecerr = 2'b11;

    // Keeps all READY outputs low while in reset and for the first cycle after release.
    logic          active_q;
    logic          aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [IW-1:0] aw_idx_q, aw_idx_d;
    logic [DW-1:0] w_data_q, w_data_d;
    logic [SW-1:0] w_strb_q, w_strb_d;
    logic          bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]    bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [NREGS-1:0] wr_pulse_q, wr_pulse_d, rd_pulse_q, rd_pulse_d;
    logic [NREGS*DW-1:0] slv_reg_q, slv_reg_d;

    logic          aw_ready, w_ready, ar_ready, aw_hs, w_hs, ar_hs, commit;
    logic [IW-1:0] cm_idx, ar_idx;
    logic [DW-1:0] cm_data, rd_val;
    logic [SW-1:0] cm_strb;
    logic          cm_mapped, ar_mapped;

    logic unused_sigs;
    assign unused_sigs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[LSB-1:0],
                           S_AXI_ARADDR[LSB-1:0]};

    // Write-path handshakes and the merged view of held/incoming AW and W beats.
    always_comb begin
        aw_ready  = active_q && !aw_held_q && !bvalid_q;
        w_ready   = active_q && !w_held_q && !bvalid_q;
        aw_hs     = S_AXI_AWVALID && aw_ready;
        w_hs      = S_AXI_WVALID && w_ready;
        cm_idx    = aw_held_q ? aw_idx_q : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:LSB];
        cm_data   = w_held_q ? w_data_q : S_AXI_WDATA;
        cm_strb   = w_held_q ? w_strb_q : S_AXI_WSTRB;
        commit    = (aw_held_q || aw_hs) && (w_held_q || w_hs);
        cm_mapped = 32'(cm_idx) < NREGS;
    end

    // Write-path next state: holding registers, response, byte-lane register update, pulse.
    always_comb begin
        aw_held_d  = aw_held_q;
        aw_idx_d   = aw_idx_q;
        w_held_d   = w_held_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        slv_reg_d  = slv_reg_q;
        wr_pulse_d = '0;
        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_idx_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:LSB];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
        end
        if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = cm_mapped ? RespOkay : RespDecerr;
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (cm_mapped && 32'(cm_idx) == i) begin
                    wr_pulse_d[i] = 1'b1;
                    if (!RO_MASK[i]) begin
                        for (int unsigned k = 0; k < SW; k++) begin
                            if (cm_strb[k]) slv_reg_d[i*DW + k*8 +: 8] = cm_data[k*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read path: AR accepted only while no response is pending, so RDATA stays stable.
    always_comb begin
        ar_ready   = active_q && !rvalid_q;
        ar_hs      = S_AXI_ARVALID && ar_ready;
        ar_idx     = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:LSB];
        ar_mapped  = 32'(ar_idx) < NREGS;
        rd_val     = '0;
        rd_pulse_d = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (ar_mapped && 32'(ar_idx) == i) begin
                rd_val        = slv_read[i*DW +: DW];
                rd_pulse_d[i] = ar_hs;
            end
        end
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = ar_mapped ? RespOkay : RespDecerr;
            rdata_d  = rd_val;
        end
    end

    // State registers; reset drops any in-flight transaction without a response.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            active_q   <= 1'b0;
            aw_held_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_held_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RespOkay;
            rvalid_q   <= 1'b0;
            rresp_q    <= RespOkay;
            rdata_q    <= '0;
            wr_pulse_q <= '0;
            rd_pulse_q <= '0;
            slv_reg_q  <= RESET_VAL;
        end else begin
            active_q   <= 1'b1;
            aw_held_q  <= aw_held_d;
            aw_idx_q   <= aw_idx_d;
            w_held_q   <= w_held_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            wr_pulse_q <= wr_pulse_d;
            rd_pulse_q <= rd_pulse_d;
            slv_reg_q  <= slv_reg_d;
        end
    end

    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = w_ready;
    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign wr_pulse      = wr_pulse_q;
    assign rd_pulse      = rd_pulse_q;
    assign slv_reg       = slv_reg_q;

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Scoreboard bench for axi_lite_regbank: 16 x 32-bit registers, reg1 read-only,
// reg3 resets to 32'h1234_5678, slv_read looped back from slv_reg.
module tb_axi_lite_regbank;

    localparam logic [15:0]  RO = 16'h0002;
    localparam logic [511:0] RV = {384'h0, 32'h1234_5678, 96'h0};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [511:0] slv_reg;
    logic [15:0]  wr_pulse, rd_pulse;
    logic [6:0]   awaddr = '0, araddr = '0;
    logic         awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic         bready = 1'b1, rready = 1'b1;
    logic         awready, wready, arready, bvalid, rvalid;
    logic [31:0]  wdata = '0, rdata;
    logic [3:0]   wstrb = '0;
    logic [1:0]   bresp, rresp;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] model [16];
    logic [1:0]  bq[$];
    logic [33:0] rq[$];

    always #5 clk = ~clk;

    axi_lite_regbank #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(7),
        .NREGS(16),
        .RO_MASK(RO),
        .RESET_VAL(RV)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESETN(rst_n),
        .slv_reg(slv_reg),
        .slv_read(slv_reg),
        .wr_pulse(wr_pulse),
        .rd_pulse(rd_pulse),
        .S_AXI_AWADDR(awaddr),
        .S_AXI_AWPROT(3'b000),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata),
        .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp),
        .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr),
        .S_AXI_ARPROT(3'b000),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata),
        .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid),
        .S_AXI_RREADY(rready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Response monitor: a handshake seen at the falling edge completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && bvalid && bready) begin
            if (bq.size() == 0) check("b_extra", {63'd0, bvalid}, 64'd0);
            else check("bresp", {62'd0, bresp}, {62'd0, bq.pop_front()});
        end
        if (rst_n && rvalid && rready) begin
            if (rq.size() == 0) check("r_extra", {63'd0, rvalid}, 64'd0);
            else check("rdata_rresp", {30'd0, rresp, rdata}, {30'd0, rq.pop_front()});
        end
    end

    function automatic logic [15:0] onehot(input logic [6:0] a);
        return (a[6:2] < 5'd16) ? (16'd1 << a[5:2]) : 16'd0;
    endfunction

    task automatic exp_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [4:0] idx = a[6:2];
        bq.push_back(idx < 5'd16 ? 2'b00 : 2'b11);
        if (idx < 5'd16 && !RO[idx[3:0]])
            for (int k = 0; k < 4; k++) if (s[k]) model[idx[3:0]][k*8 +: 8] = d[k*8 +: 8];
    endtask

    task automatic exp_read(input logic [6:0] a);
        logic [4:0] idx = a[6:2];
        if (idx < 5'd16) rq.push_back({2'b00, model[idx[3:0]]});
        else rq.push_back({2'b11, 32'h0});
    endtask

    task automatic send_aw(input logic [6:0] a);
        int n = 0;
        @(negedge clk);
        awaddr = a;
        awvalid = 1'b1;
        while (!awready && n < 100) begin @(negedge clk); n++; end
        if (!awready) check("aw_timeout", {63'd0, awready}, 64'd1);
        @(posedge clk);
        #1 awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        @(negedge clk);
        wdata = d;
        wstrb = s;
        wvalid = 1'b1;
        while (!wready && n < 100) begin @(negedge clk); n++; end
        if (!wready) check("w_timeout", {63'd0, wready}, 64'd1);
        @(posedge clk);
        #1 wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [6:0] a);
        int n = 0;
        @(negedge clk);
        araddr = a;
        arvalid = 1'b1;
        while (!arready && n < 100) begin @(negedge clk); n++; end
        if (!arready) check("ar_timeout", {63'd0, arready}, 64'd1);
        @(posedge clk);
        #1 arvalid = 1'b0;
    endtask

    // AW and W together; commit is on the later handshake, so the pulse is visible right after.
    task automatic do_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_write(a, d, s);
        fork
            send_aw(a);
            send_w(d, s);
        join
        check("wr_pulse", {48'd0, wr_pulse}, {48'd0, onehot(a)});
        check("bvalid_rise", {63'd0, bvalid}, 64'd1);
    endtask

    task automatic do_read(input logic [6:0] a);
        exp_read(a);
        send_ar(a);
        check("rd_pulse", {48'd0, rd_pulse}, {48'd0, onehot(a)});
    endtask

    task automatic drain();
        int n = 0;
        while ((bq.size() != 0 || rq.size() != 0) && n < 200) begin @(negedge clk); n++; end
        check("drain", 64'(bq.size() + rq.size()), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model[i] = RV[i*32 +: 32];

        // Reset state
        #12;
        check("rst_awready", {63'd0, awready}, 64'd0);
        check("rst_bvalid", {63'd0, bvalid}, 64'd0);
        check("rst_rvalid", {63'd0, rvalid}, 64'd0);
        check("rst_rdata", {32'd0, rdata}, 64'd0);
        check("rst_reg3", {32'd0, slv_reg[127:96]}, 64'h1234_5678);
        @(negedge clk);
        rst_n = 1'b1;

        // Read all registers after reset
        for (int i = 0; i < 16; i++) do_read(7'(i * 4));
        drain();

        // W three cycles ahead of AW
        exp_write(7'h08, 32'hCAFE_F00D, 4'hF);
        send_w(32'hCAFE_F00D, 4'hF);
        repeat (2) @(negedge clk);
        send_aw(7'h08);
        check("w_first_pulse", {48'd0, wr_pulse}, 64'h4);
        check("w_first_bvalid", {63'd0, bvalid}, 64'd1);
        check("w_first_reg2", {32'd0, slv_reg[95:64]}, 64'hCAFE_F00D);
        @(posedge clk); #1;
        check("wr_pulse_one_cycle", {48'd0, wr_pulse}, 64'd0);
        drain();

        // Partial strobe and empty strobe
        do_write(7'h14, 32'hFFFF_FFFF, 4'hF);
        do_write(7'h14, 32'h0000_00AA, 4'h1);
        check("strobe_reg5", {32'd0, slv_reg[191:160]}, 64'hFFFF_FFAA);
        do_write(7'h14, 32'h1234_5678, 4'h0);
        check("nostrobe_reg5", {32'd0, slv_reg[191:160]}, 64'hFFFF_FFAA);
        do_read(7'h14);
        drain();

        // Read-only register and unmapped addresses
        do_write(7'h04, 32'h0, 4'hF);
        do_write(7'h04, 32'hFFFF_FFFF, 4'hF);
        check("ro_reg1", {32'd0, slv_reg[63:32]}, 64'd0);
        do_read(7'h40);
        do_write(7'h44, 32'hDEAD_BEEF, 4'hF);
        do_read(7'h04);
        drain();

        // Same-cycle read and write of reg2: read returns the old value
        exp_read(7'h08);
        fork
            do_write(7'h08, 32'h1111_2222, 4'hF);
            send_ar(7'h08);
        join
        drain();
        check("concurrent_reg2", {32'd0, slv_reg[95:64]}, 64'h1111_2222);

        // B stalled for 10 cycles while a read completes
        bready = 1'b0;
        do_write(7'h1C, 32'h5555_AAAA, 4'hF);
        fork
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check("stall_bvalid", {63'd0, bvalid}, 64'd1);
                check("stall_ready", {62'd0, awready, wready}, 64'd0);
            end
            do_read(7'h08);
        join
        check("read_during_stall", 64'(rq.size()), 64'd0);
        bready = 1'b1;
        drain();

        // Reset with AW held and W outstanding
        send_aw(7'h0C);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_awready", {63'd0, awready}, 64'd0);
        check("arst_wready", {63'd0, wready}, 64'd0);
        check("arst_reg2", {32'd0, slv_reg[95:64]}, 64'd0);
        check("arst_reg3", {32'd0, slv_reg[127:96]}, 64'h1234_5678);
        for (int i = 0; i < 16; i++) model[i] = RV[i*32 +: 32];
        bq.delete();
        rq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("no_b_after_reset", {63'd0, bvalid}, 64'd0);
        end
        do_write(7'h0C, 32'hA5A5_0F0F, 4'hF);
        do_read(7'h0C);
        drain();
        check("post_reset_reg3", {32'd0, slv_reg[127:96]}, 64'hA5A5_0F0F);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_regbank.md
Name: axi_lite_regbank

Overview:
Parametrised AXI4-Lite slave register bank, successor to the fixed 16-register file that sits between the PS master port (M00_AXI) and the unit under test.
- Generalises the register count and data width.
- Adds per-register read-only masking, byte-strobe writes, decode-error responses for unmapped addresses, and single-cycle write/read event pulses so the UUT can react to software accesses.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; 32 or 64 only.
C_S_AXI_ADDR_WIDTH, 6, byte address width; must be >= clog2(NREGS)+clog2(C_S_AXI_DATA_WIDTH/8).
NREGS, 16, number of registers; 1..256.
RO_MASK, {NREGS{1'b0}}, bit i=1 makes register i read-only: writes are acknowledged OKAY but ignored.
RESET_VAL, '0, packed [NREGS-1:0][C_S_AXI_DATA_WIDTH-1:0] reset value of slv_reg.

Ports:
S_AXI_ACLK  in  1  clock.
S_AXI_ARESETN  in  1  reset; asynchronous assert, active-low.
slv_reg  out  NREGS*DW  writable register contents.
slv_read  in  NREGS*DW  read-back values, supplied per register by the UUT or looped from slv_reg.
wr_pulse  out  NREGS  one-cycle strobe: register i was written (set for RO registers as well).
rd_pulse  out  NREGS  one-cycle strobe: register i was read.
S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  standard AXI4-Lite write-address channel; AWPROT is ignored.
S_AXI_WDATA/WSTRB/WVALID/WREADY  standard write-data channel; WSTRB width is DW/8.
S_AXI_BRESP/BVALID/BREADY  standard write-response channel.
S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  standard read-address channel; ARPROT is ignored.
S_AXI_RDATA/RRESP/RVALID/RREADY  standard read-data channel.

Behaviour:
- Reset values while ARESETN=0 (applied immediately, asynchronously):
  - slv_reg = RESET_VAL.
  - All READY, VALID, wr_pulse and rd_pulse = 0; BRESP = RRESP = 0; RDATA = 0.
  - An in-flight transaction is dropped with no response.
- Address decode: index = addr[ADDR_WIDTH-1 : clog2(DW/8)]; low byte-offset bits are ignored.
  - index >= NREGS is unmapped: response DECERR (2'b11), no register change, no pulse.
- Write path:
  - AW and W are independent and either may arrive first. Each has its own one-entry holding register.
  - AWREADY = !aw_held && !bvalid; WREADY = !w_held && !bvalid.
  - Commit occurs in the first cycle both are held (or both handshakes occur in the same cycle), when not RO.
  - Commit updates each byte lane k where WSTRB[k]=1; wr_pulse[index] is asserted for the cycle following commit.
  - BVALID rises in the cycle after commit with BRESP OKAY (2'b00) or DECERR.
  - BVALID holds until BREADY; holding registers clear on commit.
  - Minimum latency: AW+W in cycle 0 gives BVALID in cycle 1.
- Read path:
  - ARREADY = !rvalid.
  - On AR handshake, RDATA is registered from slv_read[index] (0 if unmapped), RRESP is set, and RVALID rises next cycle.
  - rd_pulse[index] is asserted in that same next cycle.
  - RDATA/RRESP stay stable while RVALID && !RREADY.
  - Back-to-back throughput: 1 read per 2 cycles minimum; full rate is not required.
- Read and write are fully concurrent.
  - Same-cycle AR handshake and write commit to the same register: the read returns the pre-write slv_read value.
- The stalled master (BREADY or RREADY held low) blocks only its own channel.
- WSTRB = 0: OKAY response, no data change, wr_pulse is still asserted.

Test Plan:
- Reset, then read regs 0..NREGS-1 with slv_read looped to slv_reg and RESET_VAL[3]=32'h1234_5678 -> reg3 returns 32'h1234_5678 OKAY; all others return 0.
- W arrives 3 cycles before AW, addr 0x08, data 32'hCAFE_F00D, WSTRB 4'b1111 -> slv_reg[2]=32'hCAFE_F00D; wr_pulse[2] high exactly 1 cycle; BVALID 1 cycle after AW handshake, BRESP=00.
- Partial strobe: reg5=32'hFFFF_FFFF, then write 32'h0000_00AA with WSTRB 4'b0001 -> reg5=32'hFFFF_FFAA.
- RO_MASK[1]=1, write 32'h0 to 0x04 -> OKAY, slv_reg[1] unchanged, wr_pulse[1] asserted. Read 0x40 with NREGS=16 -> RDATA=0, RRESP=11, no rd_pulse.
- BREADY held low 10 cycles after a write -> BVALID stays high, AWREADY/WREADY stay 0; a read issued meanwhile completes with RVALID and the correct data.
- Assert ARESETN low mid-transaction with AW held and W not yet received -> outputs return to reset values immediately, no BVALID after release, and the next full write completes normally.
